// File: rtl/wallace_mul_seq.sv
// Digit-serial W x W multiplier: one 4x4 Wallace tree reused over (W/4)^2 cycles.
// Define WALLACE_MUL_SEQ_SIGNED_EN for two's-complement operands and product.

module wallacetree4x4 (
   input  logic [3:0] x_i,
   input  logic [3:0] y_i,
   output logic [7:0] p_o
);
   logic [7:0] r0, r1, r2, r3;
   logic [7:0] s1, c1, s2, c2;

   // Two 3:2 carry-save layers, then one carry-propagate add.
   always_comb begin
      r0 = {4'b0000, x_i & {4{y_i[0]}}};
      r1 = {3'b000, x_i & {4{y_i[1]}}, 1'b0};
      r2 = {2'b00, x_i & {4{y_i[2]}}, 2'b00};
      r3 = {1'b0, x_i & {4{y_i[3]}}, 3'b000};
      s1 = r0 ^ r1 ^ r2;
      c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
      s2 = s1 ^ c1 ^ r3;
      c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;
      p_o = s2 + c2;
   end
endmodule

module wallace_mul_seq #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] prod,
   output logic           busy
);
   localparam int D     = W / 4;
   localparam int STEPS = D * D;
   localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d;
   logic [KW-1:0]    k_q, k_d;
   logic [2*W-1:0]   acc_q, acc_d, prod_q, prod_d;
   logic [4:0]       i_idx, j_idx;
   logic [6:0]       sh;
   logic [3:0]       a_dig, b_dig;
   logic [7:0]       pp8;
   logic [2*W-1:0]   pp_sh, acc_sum, result;
   logic [W-1:0]     a_load, b_load;
`ifdef WALLACE_MUL_SEQ_SIGNED_EN
   logic             sign_q, sign_d;
`endif

   wallacetree4x4 u_tree (
      .x_i (a_dig),
      .y_i (b_dig),
      .p_o (pp8)
   );

   // Digit select and shifted accumulate for the current step k.
   always_comb begin
      i_idx   = 5'(32'(k_q) % D);
      j_idx   = 5'(32'(k_q) / D);
      a_dig   = 4'(a_q >> {i_idx, 2'b00});
      b_dig   = 4'(b_q >> {j_idx, 2'b00});
      sh      = {i_idx + j_idx, 2'b00};
      pp_sh   = (2*W)'(pp8) << sh;
      acc_sum = acc_q + pp_sh;
   end

`ifdef WALLACE_MUL_SEQ_SIGNED_EN
   // Magnitudes fit in W unsigned bits, including the most negative value.
   always_comb begin
      a_load = a[W-1] ? (~a + 1'b1) : a;
      b_load = b[W-1] ? (~b + 1'b1) : b;
      result = sign_q ? (~acc_sum + 1'b1) : acc_sum;
   end
`else
   always_comb begin
      a_load = a;
      b_load = b;
      result = acc_sum;
   end
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      k_d     = k_q;
      acc_d   = acc_q;
      prod_d  = prod_q;
`ifdef WALLACE_MUL_SEQ_SIGNED_EN
      sign_d  = sign_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a_load;
               b_d     = b_load;
               k_d     = '0;
               acc_d   = '0;
`ifdef WALLACE_MUL_SEQ_SIGNED_EN
               sign_d  = a[W-1] ^ b[W-1];
`endif
               state_d = MUL;
            end
         end
         MUL: begin
            acc_d = acc_sum;
            k_d   = k_q + 1'b1;
            if (k_q == KW'(STEPS - 1)) begin
               k_d     = '0;
               prod_d  = result;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         prod_q  <= '0;
`ifdef WALLACE_MUL_SEQ_SIGNED_EN
         sign_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
`ifdef WALLACE_MUL_SEQ_SIGNED_EN
         sign_q  <= sign_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign prod      = prod_q;
endmodule
